// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and optional
// two-entry skid buffer. CTRL reads as zero whenever the stage is empty, so a bubble is a NOP.
module pipe_stage_reg #(
    parameter int DATA_WIDTH = 96,
    parameter int CTRL_WIDTH = 13,
    parameter int SKID_EN    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [1:0]            occupancy,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] main_data_reg;
    logic [CTRL_WIDTH-1:0] main_ctrl_reg;
    logic [DATA_WIDTH-1:0] skid_data_reg;
    logic [CTRL_WIDTH-1:0] skid_ctrl_reg;
    logic                  push;
    logic                  pop;

    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_data_reg;
    assign out_ctrl  = main_ctrl_reg;
    assign occupancy = state_reg;

    // With the skid buffer, in_ready depends only on state, breaking the out_ready->in_ready path.
    generate
        if (SKID_EN != 0) begin : g_skid_ready
            assign in_ready = (state_reg != TWO);
        end else begin : g_pass_ready
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            main_ctrl_reg <= '0;
            skid_data_reg <= '0;
            skid_ctrl_reg <= '0;
        end else if (flush) begin
            // Data is held so downstream debug still sees the last payload; ctrl becomes a NOP.
            state_reg     <= EMPTY;
            main_ctrl_reg <= '0;
            skid_ctrl_reg <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (push) begin
                        state_reg     <= ONE;
                        main_data_reg <= in_data;
                        main_ctrl_reg <= in_ctrl;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_data_reg <= in_data;
                        main_ctrl_reg <= in_ctrl;
                    end else if (push && (SKID_EN != 0)) begin
                        state_reg     <= TWO;
                        skid_data_reg <= in_data;
                        skid_ctrl_reg <= in_ctrl;
                    end else if (pop) begin
                        state_reg     <= EMPTY;
                        main_ctrl_reg <= '0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_reg     <= ONE;
                        main_data_reg <= skid_data_reg;
                        main_ctrl_reg <= skid_ctrl_reg;
                        skid_ctrl_reg <= '0;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

    // Index 0 counts stalls, index 1 counts bubbles; both saturate at all-ones.
    logic [1:0]           cnt_evt;
    logic [CNT_WIDTH-1:0] cnt_reg [2];

    assign cnt_evt[0] = out_valid && !out_ready;
    assign cnt_evt[1] = !out_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_clr) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_evt[gi] && (cnt_reg[gi] != {CNT_WIDTH{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt  = cnt_reg[0];
    assign bubble_cnt = cnt_reg[1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one skid instance (4-bit counters) and one
// pass-through instance; monitors pop expected payloads whenever a transfer completes.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Skid instance signals
    logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1, cnt_clr1;
    logic [15:0] in_data1, out_data1;
    logic [3:0]  in_ctrl1, out_ctrl1;
    logic [1:0]  occ1;
    logic [3:0]  stall1, bubble1;

    // Pass-through instance signals
    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0, cnt_clr0;
    logic [15:0] in_data0, out_data0;
    logic [3:0]  in_ctrl0, out_ctrl0;
    logic [1:0]  occ0;
    logic [15:0] stall0, bubble0;

    logic [19:0] q1[$];
    logic [19:0] q0[$];

    pipe_stage_reg #(.DATA_WIDTH(16), .CTRL_WIDTH(4), .SKID_EN(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_ctrl(in_ctrl1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_ctrl(out_ctrl1), .occupancy(occ1), .cnt_clr(cnt_clr1),
        .stall_cnt(stall1), .bubble_cnt(bubble1)
    );

    pipe_stage_reg #(.DATA_WIDTH(16), .CTRL_WIDTH(4), .SKID_EN(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .in_ctrl(in_ctrl0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occ0), .cnt_clr(cnt_clr0),
        .stall_cnt(stall0), .bubble_cnt(bubble0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    // Monitors: one line per completed output transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
            n_tests++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL mon1: got %0h/%0h expected nothing", out_data1, out_ctrl1);
            end else begin
                logic [19:0] e;
                e = q1.pop_front();
                if ({out_data1, out_ctrl1} !== e) begin
                    n_fail++;
                    $display("FAIL mon1: got %0h/%0h expected %0h/%0h",
                             out_data1, out_ctrl1, e[19:4], e[3:0]);
                end else begin
                    $display("[TB] mon1 %0h/%0h", out_data1, out_ctrl1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid0 === 1'b1 && out_ready0 === 1'b1) begin
            n_tests++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL mon0: got %0h/%0h expected nothing", out_data0, out_ctrl0);
            end else begin
                logic [19:0] e;
                e = q0.pop_front();
                if ({out_data0, out_ctrl0} !== e) begin
                    n_fail++;
                    $display("FAIL mon0: got %0h/%0h expected %0h/%0h",
                             out_data0, out_ctrl0, e[19:4], e[3:0]);
                end else begin
                    $display("[TB] mon0 %0h/%0h", out_data0, out_ctrl0);
                end
            end
        end
    end

    // One clock cycle on the skid instance; called just after a rising edge.
    task automatic cyc1(input logic v, input logic [15:0] d, input logic [3:0] c,
                        input logic rdy, input logic fl, input logic clr);
        in_valid1 = v; in_data1 = d; in_ctrl1 = c;
        out_ready1 = rdy; flush1 = fl; cnt_clr1 = clr;
        @(negedge clk); #1;
        if (v && in_ready1 && !fl) q1.push_back({d, c});
        @(posedge clk); #1;
    endtask

    task automatic cyc0(input logic v, input logic [15:0] d, input logic [3:0] c, input logic rdy);
        in_valid0 = v; in_data0 = d; in_ctrl0 = c; out_ready0 = rdy;
        @(negedge clk); #1;
        if (v && in_ready0) q0.push_back({d, c});
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush1 = 0; in_valid1 = 0; in_data1 = 0; in_ctrl1 = 0; out_ready1 = 0; cnt_clr1 = 0;
        flush0 = 0; in_valid0 = 0; in_data0 = 0; in_ctrl0 = 0; out_ready0 = 0; cnt_clr0 = 0;
        #2;
        check("rst_out_valid", out_valid1, 0);
        check("rst_occ", occ1, 0);
        check("rst_out_data", out_data1, 0);
        check("rst_in_ready", in_ready1, 1);
        check("rst_in_ready0", in_ready0, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming: one-cycle latency, single entry held
        for (int i = 1; i <= 8; i++) begin
            cyc1(1'b1, 16'(i), 4'(i), 1'b1, 1'b0, 1'b0);
            if (i == 1) begin
                check("stream_latency_valid", out_valid1, 1);
                check("stream_latency_data", out_data1, 1);
            end
            check("stream_occ", occ1, 1);
        end
        cyc1(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("stream_stall_cnt", stall1, 0);
        check("drain_occ", occ1, 0);
        check("drain_ctrl_zero", out_ctrl1, 0);
        check("drain_data_held", out_data1, 8);

        // Skid: second push lands in skid entry, then both drain in order
        cyc1(1'b1, 16'h00A1, 4'h1, 1'b0, 1'b0, 1'b0);
        check("skid_occ1", occ1, 1);
        cyc1(1'b1, 16'h00B2, 4'h2, 1'b0, 1'b0, 1'b0);
        check("skid_occ2", occ1, 2);
        check("skid_in_ready", in_ready1, 0);
        cyc1(1'b1, 16'h00C3, 4'h3, 1'b0, 1'b0, 1'b0);
        check("skid_hold_occ", occ1, 2);
        check("skid_hold_data", out_data1, 16'h00A1);
        cyc1(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("skid_drain_occ1", occ1, 1);
        check("skid_drain_data", out_data1, 16'h00B2);
        cyc1(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("skid_drain_occ0", occ1, 0);

        // Flush from TWO with a pending push, then flush discarding an accepted push
        cyc1(1'b1, 16'h00D4, 4'h4, 1'b0, 1'b0, 1'b0);
        cyc1(1'b1, 16'h00E5, 4'h5, 1'b0, 1'b0, 1'b0);
        check("flush_pre_occ", occ1, 2);
        cyc1(1'b1, 16'h00F6, 4'h6, 1'b0, 1'b1, 1'b0);
        q1.delete();
        check("flush_valid", out_valid1, 0);
        check("flush_ctrl", out_ctrl1, 0);
        check("flush_occ", occ1, 0);
        check("flush_data_held", out_data1, 16'h00D4);
        cyc1(1'b1, 16'h0107, 4'h7, 1'b0, 1'b0, 1'b0);
        check("flush2_pre_occ", occ1, 1);
        cyc1(1'b1, 16'h0118, 4'h8, 1'b0, 1'b1, 1'b0);
        q1.delete();
        check("flush2_occ", occ1, 0);
        cyc1(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc1(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("flush2_absent", out_valid1, 0);

        // Counter clear, exact increments and saturation
        cyc1(1'b1, 16'h0129, 4'h9, 1'b0, 1'b0, 1'b1);
        check("cnt_clr_stall", stall1, 0);
        check("cnt_clr_bubble", bubble1, 0);
        for (int i = 0; i < 3; i++) cyc1(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("stall_cnt_3", stall1, 3);
        for (int i = 0; i < 17; i++) cyc1(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("stall_cnt_sat", stall1, 15);
        check("stall_no_bubble", bubble1, 0);
        check("stall_data_stable", out_data1, 16'h0129);
        cyc1(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("stall_cnt_clr", stall1, 0);
        cyc1(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc1(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("bubble_cnt_3", bubble1, 3);
        for (int i = 0; i < 20; i++) cyc1(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("bubble_cnt_sat", bubble1, 15);

        // Pass-through instance: comb in_ready, single entry
        cyc0(1'b1, 16'h1234, 4'h3, 1'b0);
        check("p0_occ1", occ0, 1);
        cyc0(1'b1, 16'h5555, 4'h5, 1'b0);
        cyc0(1'b1, 16'h5555, 4'h5, 1'b0);
        check("p0_full_occ", occ0, 1);
        check("p0_stall_cnt", stall0, 2);
        in_valid0 = 1'b1; in_data0 = 16'h6789; in_ctrl0 = 4'h6; out_ready0 = 1'b0;
        #1;
        check("p0_in_ready_low", in_ready0, 0);
        out_ready0 = 1'b1;
        #1;
        check("p0_in_ready_comb", in_ready0, 1);
        cyc0(1'b1, 16'h6789, 4'h6, 1'b1);
        check("p0_pass_data", out_data0, 16'h6789);
        check("p0_pass_occ", occ0, 1);
        cyc0(1'b1, 16'h9ABC, 4'hC, 1'b1);
        cyc0(1'b0, 16'h0, 4'h0, 1'b1);
        check("p0_drain_occ", occ0, 0);
        check("p0_drain_ctrl", out_ctrl0, 0);

        // Asynchronous reset with two entries held
        cyc1(1'b1, 16'h0A0A, 4'h5, 1'b0, 1'b0, 1'b0);
        cyc1(1'b1, 16'h0B0B, 4'h6, 1'b0, 1'b0, 1'b0);
        check("arst_pre_occ", occ1, 2);
        check("arst_pre_stall", stall1, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid1, 0);
        check("arst_ctrl", out_ctrl1, 0);
        check("arst_data", out_data1, 0);
        check("arst_occ", occ1, 0);
        check("arst_stall", stall1, 0);
        check("arst_bubble", bubble1, 0);
        q1.delete();
        q0.delete();
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cyc1(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("arst_after_valid", out_valid1, 0);

        check("q1_empty", 64'(q1.size()), 0);
        check("q0_empty", 64'(q0.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
